// File: rtl/display_scanner.sv
// Six-digit multiplexed seven-segment scanner with double-buffered frame registers.
// A loaded frame is held in shadow and committed to the active set only at a frame wrap.
module display_scanner #(
  parameter int unsigned DIV  = 50000,
  parameter int unsigned DEAD = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] in4,
  input  logic [3:0] in5,
  input  logic [5:0] DP_in,
  input  logic [5:0] Blank,
  input  logic       load,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic [5:0] dig_en,
  output logic       frame_done,
  output logic       pending
);

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

  typedef struct packed {
    logic [5:0][3:0] digits;
    logic [5:0]      dp;
    logic [5:0]      blank;
  } frame_t;

  localparam logic [19:0] DIV_LAST  = 20'(DIV - 1);
  localparam logic [19:0] DEAD_LAST = 20'(DEAD - 1);
  localparam frame_t      FRAME_RST = {24'h00_0000, 6'h00, 6'h3F};

  state_t     state_r, state_nxt_s;
  logic [19:0] cnt_r, cnt_nxt_s;
  logic [2:0]  idx_r, idx_nxt_s;
  logic        wrap_s;
  frame_t      active_r, active_nxt_s, shadow_r, in_frame_s;
  logic        pending_r, pending_nxt_s, frame_done_r;
  logic [6:0]  seg_r, seg_nxt_s;
  logic        dp_n_r, dp_n_nxt_s;
  logic [5:0]  dig_en_r, dig_en_nxt_s;

  function automatic logic [6:0] hex_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Gather the input pins into one frame image.
  always_comb begin
    in_frame_s.digits = {in5, in4, in3, in2, in1, in0};
    in_frame_s.dp     = DP_in;
    in_frame_s.blank  = Blank;
  end

  // Scan sequencing: SHOW/GAP timing, digit index advance and frame wrap detection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + 20'd1;
    idx_nxt_s   = idx_r;
    wrap_s      = 1'b0;
    case (state_r)
      SHOW: begin
        if (cnt_r == DIV_LAST) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = 20'd0;
        end else begin
          state_nxt_s = SHOW;
        end
      end
      GAP: begin
        if (cnt_r == DEAD_LAST) begin
          state_nxt_s = SHOW;
          cnt_nxt_s   = 20'd0;
          if (idx_r >= 3'd5) begin
            idx_nxt_s = 3'd0;
            wrap_s    = 1'b1;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: begin
        state_nxt_s = SHOW;
        cnt_nxt_s   = 20'd0;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // Commit: a load on the wrap cycle bypasses shadow so the newest frame always wins.
  always_comb begin
    active_nxt_s  = active_r;
    pending_nxt_s = pending_r;
    if (wrap_s) begin
      pending_nxt_s = 1'b0;
      if (load) begin
        active_nxt_s = in_frame_s;
      end else if (pending_r) begin
        active_nxt_s = shadow_r;
      end else begin
        active_nxt_s = active_r;
      end
    end else begin
      pending_nxt_s = pending_r | load;
    end
  end

  // Output image is decoded from next-cycle state so registered outputs line up with the scan.
  always_comb begin
    dig_en_nxt_s = 6'h3F;
    seg_nxt_s    = 7'h7F;
    dp_n_nxt_s   = 1'b1;
    if (state_nxt_s == SHOW) begin
      dig_en_nxt_s = ~(6'd1 << idx_nxt_s);
      dp_n_nxt_s   = ~active_nxt_s.dp[idx_nxt_s];
      if (active_nxt_s.blank[idx_nxt_s]) begin
        seg_nxt_s = 7'h7F;
      end else begin
        seg_nxt_s = hex_decode(active_nxt_s.digits[idx_nxt_s]);
      end
    end else begin
      dig_en_nxt_s = 6'h3F;
    end
  end

  // State, frame buffers and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= SHOW;
      cnt_r        <= 20'd0;
      idx_r        <= 3'd0;
      active_r     <= FRAME_RST;
      shadow_r     <= FRAME_RST;
      pending_r    <= 1'b0;
      frame_done_r <= 1'b0;
      seg_r        <= 7'h7F;
      dp_n_r       <= 1'b1;
      dig_en_r     <= 6'h3E;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      active_r     <= active_nxt_s;
      pending_r    <= pending_nxt_s;
      frame_done_r <= wrap_s;
      seg_r        <= seg_nxt_s;
      dp_n_r       <= dp_n_nxt_s;
      dig_en_r     <= dig_en_nxt_s;
      if (load) begin
        shadow_r <= in_frame_s;
      end
    end
  end

  assign seg        = seg_r;
  assign dp_n       = dp_n_r;
  assign dig_en     = dig_en_r;
  assign frame_done = frame_done_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_display_scanner.sv
// Directed and randomized bench for display_scanner (DIV=4, DEAD=2, 36-cycle frame).
// Expected outputs come from a frame-position model: phase = cycle mod 36, six digits of 6 cycles.
module tb_display_scanner;

  localparam int DIV   = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = DIV + DEAD;
  localparam int FRAME = 6 * SLOT;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_d [6];
  logic [5:0] DP_in;
  logic [5:0] Blank;
  logic       load;
  logic [6:0] seg;
  logic       dp_n;
  logic [5:0] dig_en;
  logic       frame_done;
  logic       pending;

  int n_cmp;
  int n_fail;

  // reference model: cycles since reset release plus active/shadow frame contents
  int         m_k;
  logic [3:0] m_act_dig [6];
  logic [5:0] m_act_dp, m_act_bl;
  logic [3:0] m_sh_dig [6];
  logic [5:0] m_sh_dp, m_sh_bl;
  logic       m_pend;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  display_scanner #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in0        (in_d[0]),
    .in1        (in_d[1]),
    .in2        (in_d[2]),
    .in3        (in_d[3]),
    .in4        (in_d[4]),
    .in5        (in_d[5]),
    .DP_in      (DP_in),
    .Blank      (Blank),
    .load       (load),
    .seg        (seg),
    .dp_n       (dp_n),
    .dig_en     (dig_en),
    .frame_done (frame_done),
    .pending    (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, m_k, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int p, d;
    bit show;
    logic [5:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    p    = m_k % FRAME;
    d    = p / SLOT;
    show = (p % SLOT) < DIV;
    e_en  = 6'h3F;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (show) begin
      e_en = 6'h3F & ~(6'd1 << d);
      e_dp = ~m_act_dp[d];
      if (!m_act_bl[d]) e_seg = hex_tab[m_act_dig[d]];
    end
    chk("dig_en", 32'(dig_en), 32'(e_en));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp_n", 32'(dp_n), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'((m_k > 0 && p == 0) ? 1 : 0));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic model_reset();
    m_k = 0;
    m_pend = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_act_dig[i] = 4'h0;
      m_sh_dig[i]  = 4'h0;
    end
    m_act_dp = 6'h00; m_act_bl = 6'h3F;
    m_sh_dp  = 6'h00; m_sh_bl  = 6'h3F;
  endtask

  // one clock: check current outputs, clock, then apply the frame rules to the model
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    if (m_k % FRAME == FRAME - 1) begin
      if (load) begin
        for (int i = 0; i < 6; i++) m_act_dig[i] = in_d[i];
        m_act_dp = DP_in; m_act_bl = Blank;
      end else if (m_pend) begin
        m_act_dig = m_sh_dig; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
      end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin
      for (int i = 0; i < 6; i++) m_sh_dig[i] = in_d[i];
      m_sh_dp = DP_in; m_sh_bl = Blank;
    end
    m_k++;
    @(negedge clk);
  endtask

  // called at a falling edge; asserts reset away from clock edges and checks it took effect at once
  task automatic apply_reset();
    #1 reset_n = 1'b0;
    model_reset();
    #1 check_outputs();
    #2 reset_n = 1'b1;
  endtask

  task automatic set_frame(input logic [23:0] digs, input logic [5:0] dp, input logic [5:0] bl);
    for (int i = 0; i < 6; i++) in_d[i] = digs[i*4 +: 4];
    DP_in = dp;
    Blank = bl;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < 6; i++) in_d[i] = 4'($urandom_range(0, 15));
    DP_in = 6'($urandom_range(0, 63));
    Blank = 6'($urandom_range(0, 63));
  endtask

  task automatic run_to_phase(input int ph);
    for (int n = 0; n < FRAME && (m_k % FRAME) != ph; n++) cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    load = 1'b0;
    set_frame(24'h000000, 6'h00, 6'h00);
    model_reset();
    @(negedge clk);
    apply_reset();

    // idle scan after reset: all digits blanked, frame_done every frame
    repeat (40) cycle();

    // frame 1..6 loaded at frame phase 5; pin changes afterwards must not matter
    run_to_phase(5);
    set_frame(24'h654321, 6'b000100, 6'b000000);
    load = 1'b1;
    cycle();
    load = 1'b0;
    scramble_inputs();
    repeat (80) cycle();

    // two loads before one wrap: the second replaces the first
    run_to_phase(2);
    set_frame(24'h654328, 6'b000000, 6'b000000);
    load = 1'b1;
    cycle();
    load = 1'b0;
    repeat (3) cycle();
    set_frame(24'h65432A, 6'b000000, 6'b000000);
    load = 1'b1;
    cycle();
    load = 1'b0;
    repeat (80) cycle();

    // load exactly on the wrap cycle commits directly
    run_to_phase(FRAME - 1);
    set_frame(24'h65432F, 6'b000000, 6'b000000);
    load = 1'b1;
    cycle();
    load = 1'b0;
    scramble_inputs();
    repeat (40) cycle();

    // blanked digits keep their decimal point
    run_to_phase(10);
    set_frame(24'h987654, 6'b100000, 6'b110000);
    load = 1'b1;
    cycle();
    load = 1'b0;
    repeat (80) cycle();

    // reset during SHOW of digit 3 with a frame pending discards it
    run_to_phase(12);
    set_frame(24'hABCDEF, 6'b111111, 6'b000000);
    load = 1'b1;
    cycle();
    load = 1'b0;
    run_to_phase(3 * SLOT + 1);
    apply_reset();
    repeat (80) cycle();

    // randomized frames and loads
    for (int n = 0; n < 600; n++) begin
      scramble_inputs();
      load = ($urandom_range(0, 5) == 0);
      cycle();
    end
    load = 1'b0;
    repeat (40) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter DIV, default 50000: clock cycles each digit is driven (SHOW time), legal range 2..2^20.
REQ-002 Parameter DEAD, default 500: cycles with all digits off between digits (anti-ghosting), legal range 1..2^16.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in0..in5  input  4 each  hex digit values, in0 = rightmost digit.
REQ-006 DP_in  input  6  decimal-point request per digit, bit i -> digit i, 1 = lit.
REQ-007 Blank  input  6  blank mask per digit, bit i = 1 -> segments of digit i off.
REQ-008 load  input  1  frame-valid strobe; samples in0..in5, DP_in and Blank.
REQ-009 seg  output  7  active-low segments, seg[0]=a .. seg[6]=g.
REQ-010 dp_n  output  1  active-low decimal point.
REQ-011 dig_en  output  6  active-low digit enables, at most one bit low.
REQ-012 frame_done  output  1  one-cycle pulse at each frame wrap.
REQ-013 pending  output  1  high while a loaded frame awaits commit.

Function
REQ-014 Two register sets: shadow (written on load) and active (drives display); scanning reads active only.
REQ-015 Any cycle with load=1: shadow <= inputs, pending <= 1; later loads before commit overwrite shadow (newest wins).
REQ-016 FSM states SHOW and GAP; 20-bit counter cnt; 3-bit digit index idx in 0..5.
REQ-017 SHOW: cnt counts 0..DIV-1; at cnt=DIV-1 -> GAP, cnt <= 0.
REQ-018 GAP: cnt counts 0..DEAD-1; at cnt=DEAD-1 -> SHOW, cnt <= 0, idx <= idx+1, 5 wraps to 0.
REQ-019 Frame = 6*(DIV+DEAD) cycles; wrap event = GAP end with idx=5.
REQ-020 At wrap event: frame_done=1 for that cycle; if pending=1, active <= shadow, pending <= 0.
REQ-021 Wrap event coincident with load=1: the load's input values are committed to active directly, pending <= 0.
REQ-022 SHOW, Blank_active[idx]=0: dig_en = ~(1<<idx), seg = hex decode of active digit idx, dp_n = ~DP_active[idx].
REQ-023 SHOW, Blank_active[idx]=1: dig_en = ~(1<<idx), seg = 7'h7F, dp_n = ~DP_active[idx] (DP survives blanking).
REQ-024 GAP: dig_en = 6'h3F, seg = 7'h7F, dp_n = 1.
REQ-025 Hex decode (g..a, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 Outputs derive only from registered state (FSM, idx, active regs); no combinational path from any input to any output.
REQ-027 Input changes without load never affect the display.

Reset
REQ-028 reset_n low, immediately and independent of clk: state=SHOW, cnt=0, idx=0, pending=0, frame_done=0.
REQ-029 Reset values: active Blank=6'h3F, active DP=0, active digits=0, shadow identical.
REQ-030 Resulting outputs during/after reset: dig_en=6'b111110, seg=7'h7F, dp_n=1 (digit 0 enabled, blanked).
REQ-031 reset_n asserted mid-frame aborts scan and discards a pending frame; scanning resumes at idx 0 SHOW on the first clk after release.

Verification (DIV=4, DEAD=2, frame=36 cycles)
REQ-032 Reset, no load -> dig_en walks 3E,3F,3D,3F,3B,... each 4/2 cycles, seg=7F always, frame_done every 36 cycles.
REQ-033 load with in0..in5=1,2,3,4,5,6, Blank=0, DP_in=6'b000100 at cycle 5 -> pending=1 until next wrap; next frame idx0 seg=1111001, idx2 dp_n=0, idx5 seg=0000010.
REQ-034 Two loads before one wrap (in0=8 then in0=A) -> only A displayed on digit 0; no frame shows 8.
REQ-035 load coincident with wrap cycle, in0=F -> next SHOW on idx0 shows seg=0001110, pending=0 that next cycle.
REQ-036 Blank=6'b110000, DP_in=6'b100000 loaded -> digits 4,5 seg=7F, digit 5 dp_n=0 during SHOW; GAP cycles dig_en=3F, dp_n=1; dig_en never has two low bits.
REQ-037 reset_n pulsed low during SHOW of idx 3 with pending=1 -> outputs return to REQ-030 values asynchronously, pending=0, old frame not shown after release.
